lock_sequencer: RTL and testbench
=================================

Name: lock_sequencer

Overview:
- Top-level access-control FSM for the keypad security device. Consumes the 16-bit entered-code bus, storage-full flag and enter/new-password pulses from the keypad controller.
- Holds the stored passcode, decides lock/unlock, counts failed attempts, drives the digit-store clear, and sequences passcode changes.
- Sits between the keypad controller and the lock actuator/display logic.

Parameters:
- DEFAULT_CODE, 16'h1234, passcode loaded on reset (4 BCD digits, MSD in [15:12]).
- MAX_FAILS, 3, consecutive wrong attempts before alarm/lockout; legal range 1..15.
- UNLOCK_CYCLES, 1000, cycles the lock stays open before auto-relock; must be >= 2.
- LOCKOUT_CYCLES, 5000, lockout duration; used only when LOCKOUT_EN is defined.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- digits, input, 16, entered code from the digit store.
- storage_full, input, 1, high when 4 digits are held.
- enter, input, 1, one-cycle pulse: Enter key.
- new_password, input, 1, one-cycle pulse: NewPassword key.
- clear_entry, output, 1, one-cycle pulse that clears the digit store.
- unlocked, output, 1, level; lock open.
- alarm, output, 1, level; failure threshold reached.
- fail_count, output, 4, consecutive failures; saturates at MAX_FAILS.
- state_o, output, 3, encoded state for display: LOCKED=0, UNLOCKED=1, SET_NEW=2, LOCKOUT=3.

Behaviour:
- All outputs are registered. Response appears the cycle after the triggering pulse (latency 1).
- Reset values:
  - state LOCKED; code=DEFAULT_CODE; unlocked=0; alarm=0; fail_count=0; clear_entry=0; timers=0.
  - Reset mid-operation aborts any state and restores DEFAULT_CODE.
- Priority: reset > enter > new_password. If enter and new_password arrive in the same cycle, only enter is processed.
- Every accepted enter generates clear_entry=1 for exactly one cycle, in all states except LOCKOUT.
- LOCKED:
  - enter with storage_full=1 and digits==code -> UNLOCKED; fail_count=0; alarm=0; unlock timer loaded with UNLOCK_CYCLES-1.
  - enter with a mismatch, or with storage_full=0 -> stay LOCKED; fail_count+1, saturating at MAX_FAILS.
  - When fail_count reaches MAX_FAILS: alarm=1. With LOCKOUT_EN, also go to LOCKOUT.
  - new_password is ignored.
- UNLOCKED:
  - unlocked=1; timer decrements each cycle. At 0 -> LOCKED, unlocked=0 (open for exactly UNLOCK_CYCLES cycles).
  - enter -> LOCKED immediately (manual relock).
  - new_password -> SET_NEW; clear_entry pulse; unlocked stays 1; timer reloaded.
- SET_NEW:
  - unlocked=1; timer keeps running. Expiry -> LOCKED with the code unchanged.
  - enter with storage_full=1 -> code<=digits -> LOCKED; unlocked=0.
  - enter with storage_full=0 -> stay SET_NEW; code unchanged; clear_entry pulse.
  - new_password -> abort to UNLOCKED; clear_entry pulse.
- LOCKOUT (LOCKOUT_EN only):
  - enter and new_password ignored; no clear_entry pulses; alarm=1.
  - Counts LOCKOUT_CYCLES cycles, then -> LOCKED with fail_count=0 and alarm=0.
- fail_count is never reset by a timeout, only by a successful unlock, lockout expiry or reset.
- Code comparison is the full 16 bits; no BCD validity check (the digit store filters).
- state_o encodings 4-7 are never produced.

Optional Feature:
- Macro: LOCKOUT_EN.
- Defined:
  - Reaching MAX_FAILS enters LOCKOUT for LOCKOUT_CYCLES with inputs ignored.
  - Auto-returns to LOCKED with the failure count cleared.
- Undefined:
  - No LOCKOUT state and no lockout counter logic.
  - alarm latches at MAX_FAILS and stays set until a correct code, or reset, is entered; attempts remain allowed.
  - state_o never equals 3.

Test Plan:
- Reset, digits=16'h1234, storage_full=1, enter pulse -> next cycle: unlocked=1, state_o=1, clear_entry=1 for 1 cycle. Then with UNLOCK_CYCLES=1000, unlocked drops exactly 1000 cycles later, state_o=0.
- Three enters with digits=16'h9999 (MAX_FAILS=3) -> fail_count steps 1,2,3; alarm=1 after the third.
  - With LOCKOUT_EN: state_o=3; a correct-code enter during lockout is ignored; after 5000 cycles state_o=0, fail_count=0, alarm=0.
  - Without LOCKOUT_EN: a correct code then unlocks and clears alarm and fail_count.
- Unlock, new_password, then digits=16'h4321 with enter -> state_o=0. Now 16'h1234 fails (fail_count=1) and 16'h4321 unlocks.
- enter and new_password in the same cycle while UNLOCKED -> relocks (state_o=0), no SET_NEW.
- In SET_NEW, enter with storage_full=0 -> stays state_o=2, code unchanged, clear_entry pulse. Then reset mid-SET_NEW -> state_o=0 and 16'h1234 unlocks.
- enter with storage_full=0 in LOCKED -> fail_count increments, clear_entry pulse, unlocked stays 0.

Source files
------------

// File: rtl/lock_sequencer.sv
// lock_sequencer: keypad access-control FSM holding the passcode, counting failures and timing the unlock window.
// Optional LOCKOUT_EN adds a timed LOCKOUT state once MAX_FAILS consecutive failures occur.
module lock_sequencer #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int          MAX_FAILS      = 3,
  parameter int          UNLOCK_CYCLES  = 1000,
  parameter int          LOCKOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic        storage_full,
  input  logic        enter,
  input  logic        new_password,
  output logic        clear_entry,
  output logic        unlocked,
  output logic        alarm,
  output logic [3:0]  fail_count,
  output logic [2:0]  state_o
);
  localparam int TW = $clog2((UNLOCK_CYCLES > LOCKOUT_CYCLES ? UNLOCK_CYCLES : LOCKOUT_CYCLES) + 1);
  localparam logic [TW-1:0] T_OPEN = TW'(UNLOCK_CYCLES - 1);
`ifdef LOCKOUT_EN
  localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
`endif
  localparam logic [3:0] MAXF = 4'(MAX_FAILS);

  typedef enum logic [2:0] {LOCKED = 3'd0, UNLOCKED = 3'd1, SET_NEW = 3'd2, LOCKOUT = 3'd3} state_t;

  state_t        state_q, state_d;
  logic [15:0]   code_q, code_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    fail_q, fail_d;
  logic          alarm_q, alarm_d;
  logic          clear_q, clear_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOCKED;
      code_q  <= DEFAULT_CODE;
      timer_q <= '0;
      fail_q  <= '0;
      alarm_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
      alarm_q <= alarm_d;
      clear_q <= clear_d;
    end
  end

  // The timer free-runs down to zero; only UNLOCKED/SET_NEW/LOCKOUT look at it.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    timer_d = (timer_q == '0) ? '0 : timer_q - TW'(1);
    fail_d  = fail_q;
    alarm_d = alarm_q;
    clear_d = 1'b0;
    case (state_q)
      LOCKED: if (enter) begin
        clear_d = 1'b1;
        if (storage_full && digits == code_q) begin
          state_d = UNLOCKED;
          fail_d  = '0;
          alarm_d = 1'b0;
          timer_d = T_OPEN;
        end else begin
          fail_d  = (fail_q >= MAXF) ? MAXF : fail_q + 4'd1;
          alarm_d = alarm_q | (fail_d == MAXF);
`ifdef LOCKOUT_EN
          if (fail_d == MAXF) begin
            state_d = LOCKOUT;
            timer_d = T_LOCK;
          end
`endif
        end
      end
      UNLOCKED: begin
        clear_d = enter | new_password;
        if (enter) state_d = LOCKED;
        else if (new_password) begin
          state_d = SET_NEW;
          timer_d = T_OPEN;
        end else if (timer_q == '0) state_d = LOCKED;
      end
      SET_NEW: begin
        clear_d = enter | new_password;
        if (enter && storage_full) begin
          code_d  = digits;
          state_d = LOCKED;
        end else if (timer_q == '0) state_d = LOCKED;
        else if (!enter && new_password) state_d = UNLOCKED;
      end
`ifdef LOCKOUT_EN
      LOCKOUT: if (timer_q == '0) begin
        state_d = LOCKED;
        fail_d  = '0;
        alarm_d = 1'b0;
      end
`endif
      default: state_d = LOCKED;
    endcase
  end

  always_comb begin
    state_o     = state_q;
    unlocked    = (state_q == UNLOCKED) || (state_q == SET_NEW);
    alarm       = alarm_q;
    fail_count  = fail_q;
    clear_entry = clear_q;
  end
endmodule

// File: tb/tb_lock_sequencer.sv
// tb_lock_sequencer: directed stimulus with a deadline-based behavioural model checked every cycle.
module tb_lock_sequencer;
  localparam int MAXF = 3, UNLOCK = 1000, LOCKOUT = 5000;
  localparam logic [15:0] DEF = 16'h1234;

  logic clk = 0, reset = 1, storage_full = 0, enter = 0, new_password = 0;
  logic [15:0] digits = '0;
  logic clear_entry, unlocked, alarm;
  logic [3:0] fail_count;
  logic [2:0] state_o;

  int total = 0, bad = 0;

  lock_sequencer dut (
    .clk(clk), .reset(reset), .digits(digits), .storage_full(storage_full),
    .enter(enter), .new_password(new_password), .clear_entry(clear_entry),
    .unlocked(unlocked), .alarm(alarm), .fail_count(fail_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state plus absolute-cycle deadlines for the open window and lockout.
  int m_st = 0, m_fail = 0;
  bit m_alarm = 0, m_clr = 0;
  logic [15:0] m_code = DEF;
  longint cyc = 0, open_dl = 0, lock_dl = 0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_st = 0; m_code = DEF; m_fail = 0; m_alarm = 0; m_clr = 0;
    end else begin
      m_clr = 0;
      case (m_st)
        0: if (enter) begin
          m_clr = 1;
          if (storage_full && digits == m_code) begin
            m_st = 1; m_fail = 0; m_alarm = 0; open_dl = cyc + UNLOCK;
          end else begin
            m_fail = (m_fail + 1 > MAXF) ? MAXF : m_fail + 1;
            if (m_fail == MAXF) begin
              m_alarm = 1;
`ifdef LOCKOUT_EN
              m_st = 3; lock_dl = cyc + LOCKOUT;
`endif
            end
          end
        end
        1: begin
          m_clr = enter || new_password;
          if (enter) m_st = 0;
          else if (new_password) begin m_st = 2; open_dl = cyc + UNLOCK; end
          else if (cyc == open_dl) m_st = 0;
        end
        2: begin
          m_clr = enter || new_password;
          if (enter && storage_full) begin m_code = digits; m_st = 0; end
          else if (cyc == open_dl) m_st = 0;
          else if (!enter && new_password) m_st = 1;
        end
        default: if (cyc == lock_dl) begin m_st = 0; m_fail = 0; m_alarm = 0; end
      endcase
    end
    #2;
    check("m_state", state_o, m_st);
    check("m_unlocked", unlocked, (m_st == 1 || m_st == 2) ? 1 : 0);
    check("m_alarm", alarm, m_alarm);
    check("m_fail", fail_count, m_fail);
    check("m_clear", clear_entry, m_clr);
  end

  task automatic pulse(input logic [15:0] d, input logic f, input logic e, input logic n);
    @(negedge clk);
    digits = d; storage_full = f; enter = e; new_password = n;
    @(negedge clk);
    enter = 0; new_password = 0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    reset = 0;
    check("rst_state", state_o, 0);
    check("rst_unlocked", unlocked, 0);
    check("rst_alarm", alarm, 0);
    check("rst_fail", fail_count, 0);
    check("rst_clear", clear_entry, 0);

    pulse(16'h1234, 1, 1, 0);
    check("open_unlocked", unlocked, 1);
    check("open_state", state_o, 1);
    check("open_clear", clear_entry, 1);
    @(negedge clk);
    check("open_clear_one", clear_entry, 0);
    n = 1;
    while (unlocked && n < 2000) begin @(negedge clk); n++; end
    check("open_len", n, 1000);
    check("relock_state", state_o, 0);

    pulse(16'h9999, 1, 1, 0);
    check("fail1", fail_count, 1);
    check("alarm_after1", alarm, 0);
    pulse(16'h9999, 1, 1, 0);
    check("fail2", fail_count, 2);
    check("alarm_after2", alarm, 0);
    pulse(16'h9999, 1, 1, 0);
    check("fail3", fail_count, 3);
    check("alarm_after3", alarm, 1);
`ifdef LOCKOUT_EN
    check("lockout_state", state_o, 3);
    pulse(16'h1234, 1, 1, 0);
    check("lockout_ignore", state_o, 3);
    check("lockout_noclear", clear_entry, 0);
    n = 0;
    while (state_o == 3 && n < 6000) begin @(negedge clk); n++; end
    check("lockout_end_state", state_o, 0);
    check("lockout_end_fail", fail_count, 0);
    check("lockout_end_alarm", alarm, 0);
    pulse(16'h1234, 1, 1, 0);
`else
    pulse(16'h1234, 1, 1, 0);
    check("alarm_clr_state", state_o, 1);
    check("alarm_clr_alarm", alarm, 0);
    check("alarm_clr_fail", fail_count, 0);
`endif

    pulse(16'h0000, 0, 0, 1);
    check("setnew_state", state_o, 2);
    check("setnew_unlocked", unlocked, 1);
    check("setnew_clear", clear_entry, 1);
    pulse(16'h4321, 1, 1, 0);
    check("newcode_state", state_o, 0);
    check("newcode_unlocked", unlocked, 0);
    pulse(16'h1234, 1, 1, 0);
    check("oldcode_fail", fail_count, 1);
    check("oldcode_state", state_o, 0);
    pulse(16'h4321, 1, 1, 0);
    check("newcode_open", state_o, 1);
    check("newcode_fail0", fail_count, 0);

    pulse(16'h4321, 1, 1, 1);
    check("both_relock", state_o, 0);

    pulse(16'h4321, 1, 1, 0);
    pulse(16'h0000, 0, 0, 1);
    check("setnew2_state", state_o, 2);
    pulse(16'h5555, 0, 1, 0);
    check("setnew_nofull_state", state_o, 2);
    check("setnew_nofull_clear", clear_entry, 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("midreset_state", state_o, 0);
    pulse(16'h1234, 1, 1, 0);
    check("midreset_default", state_o, 1);

    pulse(16'h0000, 0, 1, 0);
    check("manual_relock", state_o, 0);
    pulse(16'h1234, 0, 1, 0);
    check("nofull_fail", fail_count, 1);
    check("nofull_clear", clear_entry, 1);
    check("nofull_unlocked", unlocked, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
